// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock gating controller: per-channel OFF/WAKE/ON/IDLE sequencer
// with wake settle delay, idle hold-off and one glitch-free gate cell per channel.
module clock_gate_ctrl #(
  parameter int N_CH        = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            global_en,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] force_on,
  output logic [N_CH-1:0] ack,
  output logic [N_CH-1:0] ce,
  output logic            any_on,
  output logic [N_CH-1:0] clk_gated
);

  localparam int MAX_C = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [CNT_W-1:0] WAKE_LD = (WAKE_CYCLES > 0) ? CNT_W'(WAKE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } state_t;

  logic [N_CH-1:0] w_want;

  assign w_want = {N_CH{global_en}} & (req | force_on);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ce;
    logic             r_ack;
    logic             r_ce_neg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= S_OFF;
        r_cnt   <= '0;
        r_ce    <= 1'b0;
        r_ack   <= 1'b0;
      end else if (!global_en) begin
        r_state <= S_OFF;
        r_cnt   <= '0;
        r_ce    <= 1'b0;
        r_ack   <= 1'b0;
      end else begin
        case (r_state)
          S_OFF: begin
            if (w_want[g]) begin
              if (WAKE_CYCLES > 0) begin
                r_state <= S_WAKE;
                r_cnt   <= WAKE_LD;
                r_ce    <= 1'b1;
                r_ack   <= 1'b0;
              end else begin
                r_state <= S_ON;
                r_ce    <= 1'b1;
                r_ack   <= 1'b1;
              end
            end
          end
          // WAKE runs to completion even if the request goes away
          S_WAKE: begin
            if (r_cnt == '0) begin
              r_state <= S_ON;
              r_ack   <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          S_ON: begin
            if (!w_want[g]) begin
              r_state <= S_IDLE;
              r_cnt   <= IDLE_LD;
            end
          end
          S_IDLE: begin
            if (w_want[g]) begin
              r_state <= S_ON;
            end else if (r_cnt == '0) begin
              r_state <= S_OFF;
              r_ce    <= 1'b0;
              r_ack   <= 1'b0;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          default: begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_ce    <= 1'b0;
            r_ack   <= 1'b0;
          end
        endcase
      end
    end

    // Gate cell: CE is captured while clk is low, as the BUFGCE does, so only
    // whole high pulses pass through.
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        r_ce_neg <= 1'b0;
      end else begin
        r_ce_neg <= r_ce;
      end
    end

    assign clk_gated[g] = clk & r_ce_neg;
    assign ce[g]        = r_ce;
    assign ack[g]       = r_ack;
  end

  assign any_on = |ce;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed scoreboard bench for clock_gate_ctrl: a WAKE=2/IDLE=16 instance and
// a WAKE=0 instance share clock, reset and global enable.
module tb_clock_gate_ctrl;

  logic       clk;
  logic       rst;
  logic       global_en;
  logic [3:0] req, force_on, req_z, force_z;
  logic [3:0] ack, ce, clk_gated;
  logic [3:0] ack_z, ce_z, clk_gated_z;
  logic       any_on, any_on_z;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] e_ce, e_ack, e_ce_z, e_ack_z;
  logic [3:0] prev_ce, prev_ce_z;

  typedef struct {
    string      tag;
    logic [3:0] ce;
    logic [3:0] ack;
    logic [3:0] ce_z;
    logic [3:0] ack_z;
    logic [3:0] gated;
    logic [3:0] gated_z;
  } exp_t;

  exp_t sb[$];

  clock_gate_ctrl #(.N_CH(4), .WAKE_CYCLES(2), .IDLE_CYCLES(16)) u_dut (
    .clk(clk), .rst(rst), .global_en(global_en), .req(req), .force_on(force_on),
    .ack(ack), .ce(ce), .any_on(any_on), .clk_gated(clk_gated)
  );

  clock_gate_ctrl #(.N_CH(4), .WAKE_CYCLES(0), .IDLE_CYCLES(16)) u_dut_z (
    .clk(clk), .rst(rst), .global_en(global_en), .req(req_z), .force_on(force_z),
    .ack(ack_z), .ce(ce_z), .any_on(any_on_z), .clk_gated(clk_gated_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    e.tag     = tag;
    e.ce      = e_ce;
    e.ack     = e_ack;
    e.ce_z    = e_ce_z;
    e.ack_z   = e_ack_z;
    e.gated   = prev_ce;
    e.gated_z = prev_ce_z;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "/ce"},      32'(ce),          32'(e.ce));
    chk({e.tag, "/ack"},     32'(ack),         32'(e.ack));
    chk({e.tag, "/any_on"},  32'(any_on),      32'(|e.ce));
    chk({e.tag, "/gated"},   32'(clk_gated),   32'(e.gated));
    chk({e.tag, "/ce_z"},    32'(ce_z),        32'(e.ce_z));
    chk({e.tag, "/ack_z"},   32'(ack_z),       32'(e.ack_z));
    chk({e.tag, "/gated_z"}, 32'(clk_gated_z), 32'(e.gated_z));
    @(negedge clk);
    #1;
    chk({e.tag, "/gated_low"}, 32'({clk_gated, clk_gated_z}), 32'(0));
    prev_ce   = e.ce;
    prev_ce_z = e.ce_z;
  endtask

  task automatic hold(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic chk_zero_now(input string tag);
    chk({tag, "/ce"},     32'({ce, ce_z}),         32'(0));
    chk({tag, "/ack"},    32'({ack, ack_z}),       32'(0));
    chk({tag, "/any_on"}, 32'({any_on, any_on_z}), 32'(0));
    chk({tag, "/gated"},  32'({clk_gated, clk_gated_z}), 32'(0));
  endtask

  initial begin
    rst = 1'b1; global_en = 1'b1;
    req = '0; force_on = '0; req_z = '0; force_z = '0;
    e_ce = '0; e_ack = '0; e_ce_z = '0; e_ack_z = '0;
    prev_ce = '0; prev_ce_z = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero_now("reset");
    @(negedge clk); #1;
    rst = 1'b0;
    hold("post_rst", 2);

    // Wake channel 1: ce after E, ack after E+2
    req[1] = 1'b1;
    e_ce = 4'b0010;
    step("wake1_e0");
    step("wake1_e1");
    e_ack = 4'b0010;
    step("wake1_e2");
    hold("on1", 3);

    // Idle gating of channel 1: 16 edges held, fall on edge 16
    req[1] = 1'b0;
    hold("idle1", 16);
    e_ce = '0; e_ack = '0;
    step("gate1");
    step("off1");

    // Re-request during IDLE on channel 0
    req[0] = 1'b1;
    e_ce = 4'b0001;
    hold("wake0", 2);
    e_ack = 4'b0001;
    hold("on0", 2);
    req[0] = 1'b0;
    hold("idle0_a", 10);
    req[0] = 1'b1;
    hold("rereq0", 3);
    req[0] = 1'b0;
    hold("idle0_b", 16);
    e_ce = '0; e_ack = '0;
    step("gate0");

    // WAKE_CYCLES=0 instance: ce and ack together on the first edge
    req_z[3] = 1'b1;
    e_ce_z = 4'b1000; e_ack_z = 4'b1000;
    step("z_wake");
    step("z_on");
    req_z[3] = 1'b0;
    hold("z_idle", 16);
    e_ce_z = '0; e_ack_z = '0;
    step("z_gate");

    // One-cycle request on channel 3: full wake, one ON cycle, full hold-off
    req[3] = 1'b1;
    e_ce = 4'b1000;
    step("pulse3_e0");
    req[3] = 1'b0;
    step("pulse3_e1");
    e_ack = 4'b1000;
    step("pulse3_on");
    hold("pulse3_idle", 16);
    e_ce = '0; e_ack = '0;
    step("pulse3_gate");

    // force_on keeps channel 2 alive, global_en overrides it
    force_on[2] = 1'b1;
    e_ce = 4'b0100;
    hold("force2_wake", 2);
    e_ack = 4'b0100;
    hold("force2_on", 20);
    global_en = 1'b0;
    e_ce = '0; e_ack = '0;
    hold("gen_off", 3);
    global_en = 1'b1;
    e_ce = 4'b0100;
    hold("gen_rewake", 2);
    e_ack = 4'b0100;
    step("gen_on");
    force_on[2] = 1'b0;
    hold("force2_idle", 16);
    e_ce = '0; e_ack = '0;
    step("force2_gate");

    // Asynchronous reset mid-WAKE
    req[0] = 1'b1;
    e_ce = 4'b0001;
    step("arst_wake");
    #2;
    rst = 1'b1;
    #1;
    chk_zero_now("arst_wake_now");
    @(posedge clk); #1;
    chk_zero_now("arst_wake_held");
    @(negedge clk); #1;
    rst = 1'b0;
    prev_ce = '0; prev_ce_z = '0;
    e_ce = 4'b0001; e_ack = '0;
    hold("restart_wake", 2);
    e_ack = 4'b0001;
    step("restart_on");

    // Asynchronous reset mid-IDLE
    req[0] = 1'b0;
    hold("arst_idle_pre", 3);
    #2;
    rst = 1'b1;
    #1;
    chk_zero_now("arst_idle_now");
    @(negedge clk); #1;
    rst = 1'b0;
    prev_ce = '0; prev_ce_z = '0;
    e_ce = '0; e_ack = '0;
    hold("after_arst", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
